// File: rtl/alu_result_buffer_pkg.sv
// Shared types and constants for the ALU result buffer slice.
// PSW bit positions are fixed here so the top and any consumers agree on layout.
package alu_pkg;

  localparam int ALU_DW = 8;
  localparam int PSW_W  = 4;

  localparam int CY = 3;
  localparam int AC = 2;
  localparam int OV = 1;
  localparam int P  = 0;

  typedef struct packed {
    logic [3:0]        op;
    logic [ALU_DW-1:0] des1;
    logic [ALU_DW-1:0] des2;
    logic [ALU_DW-1:0] acc;
  } alu_result_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// ALU-result capture bus plus register-file writer drain handshake and status.
// slave is the buffer side, master is the ALU/writer side.
interface alu_result_buffer_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [3:0]    in_op;
  logic [DW-1:0] in_des1;
  logic [DW-1:0] in_des2;
  logic [DW-1:0] in_acc;
  logic          in_cy;
  logic          in_ac;
  logic          in_ov;

  logic          wb_ready;
  logic          wb_valid;
  logic [3:0]    wb_op;
  logic [DW-1:0] wb_des1;
  logic [DW-1:0] wb_des2;
  logic [DW-1:0] wb_acc;

  logic          psw_cy;
  logic          psw_ac;
  logic          psw_ov;
  logic          psw_p;
  logic [CW-1:0] count;
  logic          full;
  logic          overrun;
  logic          clr_overrun;

  modport slave (
    input  in_valid, in_op, in_des1, in_des2, in_acc, in_cy, in_ac, in_ov,
    input  wb_ready, clr_overrun,
    output wb_valid, wb_op, wb_des1, wb_des2, wb_acc,
    output psw_cy, psw_ac, psw_ov, psw_p, count, full, overrun
  );

  modport master (
    output in_valid, in_op, in_des1, in_des2, in_acc, in_cy, in_ac, in_ov,
    output wb_ready, clr_overrun,
    input  wb_valid, wb_op, wb_des1, wb_des2, wb_acc,
    input  psw_cy, psw_ac, psw_ov, psw_p, count, full, overrun
  );

endinterface

// File: rtl/alu_result_buffer_fifo.sv
// Generic synchronous FIFO, occupancy-counted; head readable combinationally, write visible next cycle.
// Caller guarantees push only when !full or popping, pop only when !empty.
module alu_res_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately left unreset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results into a FIFO drained over valid/ready; keeps PSW flags and a sticky overrun.
// One-cycle minimum latency; the ALU never stalls, so pushes into a full buffer without a pop are dropped.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_buffer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] des1;
    logic [DW-1:0] des2;
    logic [DW-1:0] acc;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic [PSW_W-1:0]  psw;
  logic              overrun;

  assign pop  = !empty && bus.wb_ready;
  assign push = bus.in_valid && (!full || pop);
  assign drop = bus.in_valid && full && !pop;

  assign wr_entry.op   = bus.in_op;
  assign wr_entry.des1 = bus.in_des1;
  assign wr_entry.des2 = bus.in_des2;
  assign wr_entry.acc  = bus.in_acc;

  alu_res_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_dat (wr_entry),
    .rd_dat (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Head is masked while empty so the bus reads zero out of reset instead of stale storage.
  assign bus.wb_valid = !empty;
  assign bus.wb_op    = empty ? '0 : head.op;
  assign bus.wb_des1  = empty ? '0 : head.des1;
  assign bus.wb_des2  = empty ? '0 : head.des2;
  assign bus.wb_acc   = empty ? '0 : head.acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psw <= '0;
    end else if (push) begin
      psw[CY] <= bus.in_cy;
      psw[AC] <= bus.in_ac;
      psw[OV] <= bus.in_ov;
      psw[P]  <= ^bus.in_acc;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign bus.psw_cy  = psw[CY];
  assign bus.psw_ac  = psw[AC];
  assign bus.psw_ov  = psw[OV];
  assign bus.psw_p   = psw[P];
  assign bus.count   = count;
  assign bus.full    = full;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed vector table plus hand-written wrap and asynchronous-reset sequences for alu_result_buffer.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_result_buffer_if #(.DW(8), .DEPTH(4)) bus ();

  alu_result_buffer #(.DEPTH(4), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d1;
    logic [7:0] acc;
    logic       cy, ac, ov, rdy, clr;
    logic       ev;
    logic [7:0] ed1;
    logic [7:0] eacc;
    logic [2:0] ecnt;
    logic       efull, eovr;
    logic [3:0] epsw;
  } vec_t;

  vec_t tbl [34];

  function automatic vec_t mk(input logic v, input logic [7:0] d1, input logic [7:0] acc,
                              input logic cy, input logic ac, input logic ov,
                              input logic rdy, input logic clr,
                              input logic ev, input logic [7:0] ed1, input logic [7:0] eacc,
                              input logic [2:0] ecnt, input logic efull, input logic eovr,
                              input logic [3:0] epsw);
    vec_t t;
    t.v = v; t.d1 = d1; t.acc = acc; t.cy = cy; t.ac = ac; t.ov = ov;
    t.rdy = rdy; t.clr = clr; t.ev = ev; t.ed1 = ed1; t.eacc = eacc;
    t.ecnt = ecnt; t.efull = efull; t.eovr = eovr; t.epsw = epsw;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d1, input logic [7:0] acc,
                       input logic cy, input logic ac, input logic ov,
                       input logic rdy, input logic clr);
    bus.in_valid    = v;
    bus.in_op       = d1[3:0];
    bus.in_des1     = d1;
    bus.in_des2     = ~d1;
    bus.in_acc      = acc;
    bus.in_cy       = cy;
    bus.in_ac       = ac;
    bus.in_ov       = ov;
    bus.wb_ready    = rdy;
    bus.clr_overrun = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [7:0] ed1,
                             input logic [7:0] eacc, input logic [2:0] ecnt,
                             input logic efull, input logic eovr, input logic [3:0] epsw);
    alu_result_t eh;
    alu_result_t ah;
    if (ev) begin
      eh.op = ed1[3:0]; eh.des1 = ed1; eh.des2 = ~ed1; eh.acc = eacc;
    end else begin
      eh = '0;
    end
    ah.op = bus.wb_op; ah.des1 = bus.wb_des1; ah.des2 = bus.wb_des2; ah.acc = bus.wb_acc;
    chk({tag, "_valid"},   32'(bus.wb_valid), 32'(ev));
    chk({tag, "_head"},    32'(ah),           32'(eh));
    chk({tag, "_count"},   32'(bus.count),    32'(ecnt));
    chk({tag, "_full"},    32'(bus.full),     32'(efull));
    chk({tag, "_overrun"}, 32'(bus.overrun),  32'(eovr));
    chk({tag, "_psw_cy"},  32'(bus.psw_cy),   32'(epsw[CY]));
    chk({tag, "_psw_ac"},  32'(bus.psw_ac),   32'(epsw[AC]));
    chk({tag, "_psw_ov"},  32'(bus.psw_ov),   32'(epsw[OV]));
    chk({tag, "_psw_p"},   32'(bus.psw_p),    32'(epsw[P]));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              v  d1     acc    cy ac ov rdy clr | ev ed1   eacc  cnt fu ov psw
    tbl[0]  = mk(1, 8'h11, 8'h96, 1, 0, 0, 0, 0,   1, 8'h11, 8'h96, 1, 0, 0, 4'h8);
    tbl[1]  = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 0, 4'h8);
    tbl[2]  = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 0, 4'h8);
    tbl[3]  = mk(1, 8'h01, 8'h01, 1, 0, 0, 0, 0,   1, 8'h01, 8'h01, 1, 0, 0, 4'h9);
    tbl[4]  = mk(1, 8'h02, 8'h02, 0, 0, 0, 0, 0,   1, 8'h01, 8'h01, 2, 0, 0, 4'h1);
    tbl[5]  = mk(1, 8'h03, 8'h03, 1, 0, 0, 0, 0,   1, 8'h01, 8'h01, 3, 0, 0, 4'h8);
    tbl[6]  = mk(1, 8'h04, 8'h04, 0, 0, 0, 0, 0,   1, 8'h01, 8'h01, 4, 1, 0, 4'h1);
    tbl[7]  = mk(1, 8'h05, 8'h0F, 1, 1, 1, 0, 0,   1, 8'h01, 8'h01, 4, 1, 1, 4'h1);
    tbl[8]  = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h02, 8'h02, 3, 0, 1, 4'h1);
    tbl[9]  = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h03, 8'h03, 2, 0, 1, 4'h1);
    tbl[10] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h04, 8'h04, 1, 0, 1, 4'h1);
    tbl[11] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 1, 4'h1);
    tbl[12] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1,   0, 8'h00, 8'h00, 0, 0, 0, 4'h1);
    tbl[13] = mk(1, 8'h10, 8'h10, 0, 0, 0, 0, 0,   1, 8'h10, 8'h10, 1, 0, 0, 4'h1);
    tbl[14] = mk(1, 8'h11, 8'h11, 0, 0, 0, 0, 0,   1, 8'h10, 8'h10, 2, 0, 0, 4'h0);
    tbl[15] = mk(1, 8'h12, 8'h12, 0, 0, 0, 0, 0,   1, 8'h10, 8'h10, 3, 0, 0, 4'h0);
    tbl[16] = mk(1, 8'h13, 8'h13, 0, 0, 0, 0, 0,   1, 8'h10, 8'h10, 4, 1, 0, 4'h1);
    tbl[17] = mk(1, 8'h09, 8'h09, 1, 0, 0, 1, 0,   1, 8'h11, 8'h11, 4, 1, 0, 4'h8);
    tbl[18] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h12, 8'h12, 3, 0, 0, 4'h8);
    tbl[19] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h13, 8'h13, 2, 0, 0, 4'h8);
    tbl[20] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h09, 8'h09, 1, 0, 0, 4'h8);
    tbl[21] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 0, 4'h8);
    tbl[22] = mk(1, 8'h20, 8'h00, 0, 0, 0, 0, 0,   1, 8'h20, 8'h00, 1, 0, 0, 4'h0);
    tbl[23] = mk(1, 8'h21, 8'h00, 0, 0, 0, 0, 0,   1, 8'h20, 8'h00, 2, 0, 0, 4'h0);
    tbl[24] = mk(1, 8'h22, 8'h00, 0, 0, 0, 0, 0,   1, 8'h20, 8'h00, 3, 0, 0, 4'h0);
    tbl[25] = mk(1, 8'h23, 8'h00, 0, 0, 0, 0, 0,   1, 8'h20, 8'h00, 4, 1, 0, 4'h0);
    tbl[26] = mk(1, 8'h24, 8'hFF, 1, 0, 0, 0, 1,   1, 8'h20, 8'h00, 4, 1, 1, 4'h0);
    tbl[27] = mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 1,   1, 8'h20, 8'h00, 4, 1, 0, 4'h0);
    tbl[28] = mk(1, 8'h25, 8'h07, 0, 1, 1, 1, 0,   1, 8'h21, 8'h00, 4, 1, 0, 4'h7);
    tbl[29] = mk(1, 8'h26, 8'h00, 0, 0, 0, 1, 0,   1, 8'h22, 8'h00, 4, 1, 0, 4'h0);
    tbl[30] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h23, 8'h00, 3, 0, 0, 4'h0);
    tbl[31] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h25, 8'h07, 2, 0, 0, 4'h0);
    tbl[32] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   1, 8'h26, 8'h00, 1, 0, 0, 4'h0);
    tbl[33] = mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 0, 4'h0);

    reset = 1'b1;
    drive(0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    #12;
    check_state("reset", 0, 8'h00, 8'h00, 0, 0, 0, 4'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i].v, tbl[i].d1, tbl[i].acc, tbl[i].cy, tbl[i].ac, tbl[i].ov,
            tbl[i].rdy, tbl[i].clr);
      step();
      check_state($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed1, tbl[i].eacc,
                  tbl[i].ecnt, tbl[i].efull, tbl[i].eovr, tbl[i].epsw);
    end

    // Full-throughput push/pop pairs wrap the pointers while occupancy stays at one.
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i), 8'(i), 0, 0, 0, 1, 0);
      step();
      chk($sformatf("wrap%0d_count", i), 32'(bus.count), 32'd1);
      chk($sformatf("wrap%0d_des1", i),  32'(bus.wb_des1), 32'(i));
    end
    drive(0, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    step();
    chk("wrap_drain_count", 32'(bus.count), 32'd0);

    // Build three entries with nonzero PSW, then reset between clock edges.
    drive(1, 8'h31, 8'h01, 1, 1, 1, 0, 0);
    step();
    drive(1, 8'h32, 8'h02, 1, 1, 1, 0, 0);
    step();
    drive(1, 8'h33, 8'h01, 1, 1, 1, 0, 0);
    step();
    check_state("preburst", 1, 8'h31, 8'h01, 3, 0, 0, 4'hF);
    drive(0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_state("midreset", 0, 8'h00, 8'h00, 0, 0, 0, 4'h0);
    #1 reset = 1'b0;

    drive(1, 8'h11, 8'h96, 1, 0, 0, 0, 0);
    step();
    check_state("post_push", 1, 8'h11, 8'h96, 1, 0, 0, 4'h8);
    drive(0, 8'h00, 8'h00, 0, 0, 0, 1, 0);
    step();
    check_state("post_pop", 0, 8'h00, 8'h00, 0, 0, 0, 4'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit ALU. Captures every result bundle the ALU emits on its valid_out strobe.
- Maintains the architectural PSW flags (CY, AC, OV, P).
- Holds results in a small FIFO until the register-file writer drains them over a valid/ready handshake.
- The ALU cannot stall, so this block absorbs bursts and flags any lost result.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- DW, 8, data width of des1/des2/des_acc

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU valid_out strobe; one result per cycle when high
- in_op  input  4  opcode tag of the result, aligned with in_valid
- in_des1  input  DW  ALU des1
- in_des2  input  DW  ALU des2
- in_acc  input  DW  ALU des_acc
- in_cy  input  1  ALU desCy
- in_ac  input  1  ALU desAC
- in_ov  input  1  ALU desOv
- wb_ready  input  1  writer accepts the head entry this cycle
- wb_valid  output  1  head entry is available
- wb_op  output  4  head opcode tag
- wb_des1  output  DW  head des1
- wb_des2  output  DW  head des2
- wb_acc  output  DW  head accumulator value
- psw_cy  output  1  carry flag
- psw_ac  output  1  auxiliary-carry flag
- psw_ov  output  1  overflow flag
- psw_p  output  1  parity: XOR-reduce of the last captured in_acc
- count  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  count == DEPTH
- overrun  output  1  sticky: a result was dropped
- clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, active-high):
  - wr_ptr = rd_ptr = 0, count = 0, wb_valid = 0.
  - wb_op, wb_des1, wb_des2, wb_acc = 0.
  - All psw_* = 0, full = 0, overrun = 0.
  - FIFO storage is not reset.
- Push:
  - push = in_valid && (!full || pop).
  - On push, write {in_op, in_des1, in_des2, in_acc} at wr_ptr and increment wr_ptr modulo DEPTH.
- Pop:
  - pop = wb_valid && wb_ready.
  - On pop, increment rd_ptr modulo DEPTH.
- Occupancy:
  - count +1 on push only, -1 on pop only, unchanged on both.
  - A push when full is accepted only if a pop occurs in the same cycle.
- Overrun:
  - in_valid && full && !pop drops the entry.
  - overrun sets on the next edge and stays set until clr_overrun.
  - Set has priority over a simultaneous clr_overrun.
  - PSW is not updated by a dropped entry.
- PSW update:
  - Registered. On every accepted push: psw_cy <= in_cy, psw_ac <= in_ac, psw_ov <= in_ov, psw_p <= ^in_acc.
  - Flags are visible the cycle after capture, independent of drain.
- Output path:
  - wb_* are driven combinationally from the FIFO head.
  - wb_valid = (count != 0).
  - No bypass: a push into an empty FIFO gives wb_valid = 1 one cycle later, so minimum latency is 1 cycle.
- Handshake:
  - wb_valid holds and wb_* stay stable until pop.
  - wb_ready while !wb_valid has no effect.
- Pointer wrap: natural modulo DEPTH. full/empty are derived from count, never from pointer equality alone.
- Reset mid-operation: all entries are discarded, and wb_valid falls asynchronously.

Decomposition:
- Package alu_pkg:
  - typedef alu_result_t {op[3:0], des1, des2, acc}
  - constant PSW_W = 4
  - PSW bit-index constants CY=3, AC=2, OV=1, P=0
- One sub-module: alu_res_fifo, a generic parameterised sync FIFO (push/pop/count/full/empty).
- PSW and overrun logic stay in the top module.

Test Plan:
- Single push: in_valid=1, in_acc=8'h96, in_cy=1, in_ov=0, wb_ready=0.
  - Next cycle: wb_valid=1, wb_acc=96, psw_cy=1, psw_p=0, count=1.
  - Then wb_ready=1: count=0 and wb_valid=0 after the edge.
- Fill and overrun (DEPTH=4): 5 consecutive pushes with in_des1 = 1..5 and wb_ready=0.
  - full=1 after 4 pushes, overrun=1 after the 5th.
  - Drain yields 1,2,3,4.
  - PSW reflects push 4, not push 5.
- Full with simultaneous push/pop: count=4, in_valid=1 (des1=9), wb_ready=1.
  - count stays 4, overrun stays 0.
  - 9 emerges after 3 further pops.
- Wrap-around: 10 push/pop pairs at full throughput with des1 = 0..9.
  - In-order output 0..9, count never exceeds 1.
- Parity and flags: push in_acc=8'h07 with ac=1, ov=1.
  - psw_p=1, psw_ac=1, psw_ov=1.
  - Then push in_acc=8'h00 with all flags 0: all psw_*=0.
- Reset mid-burst: with count=3, pulse reset asynchronously between edges.
  - wb_valid=0, count=0, psw_*=0, overrun=0 immediately.
  - A subsequent push behaves as the Single push scenario.
